// File: rtl/clocks_6502_pkg.sv
// Shared constants for the 6502 clock/reset generator.
// Counter widths are sized from the legal parameter ranges.
package clocks_6502_pkg;

    localparam int CLK_DIV_DEFAULT      = 4;
    localparam int RESET_CYCLES_DEFAULT = 8;

    localparam int CLK_DIV_MAX      = 255;
    localparam int RESET_CYCLES_MAX = 65535;

    localparam int HC_W          = $clog2(CLK_DIV_MAX + 1);
    localparam int FC_W          = $clog2(RESET_CYCLES_MAX + 1);
    localparam int CYCLE_COUNT_W = 32;

endpackage

// File: rtl/clocks_6502_clk_divider.sv
// Divides eclk by 2*DIV into a registered 50% clk. The rise/fall strobes are
// high for the single eclk cycle whose next rising edge toggles clk.
module clk_divider
    import clocks_6502_pkg::*;
#(
    parameter int DIV = CLK_DIV_DEFAULT
) (
    input  logic eclk,
    input  logic ereset,
    output logic clk,
    output logic rise,
    output logic fall
);

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(DIV - 1);

    logic [HC_W-1:0] hc;
    logic            wrap;

    assign wrap = (hc == HC_LAST);
    assign rise = wrap & ~clk;
    assign fall = wrap & clk;

    // clk comes straight from a flop, so the output cannot glitch.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            hc  <= '0;
            clk <= 1'b0;
        end else if (wrap) begin
            hc  <= '0;
            clk <= ~clk;
        end else begin
            hc  <= hc + 1'b1;
        end
    end

endmodule

// File: rtl/clocks_6502.sv
// 6502 clock and reset generator: divided CPU clock plus a registered
// active-low reset released after RESET_CYCLES clk periods.
// Optional cycle counter: define CLOCKS_6502_CYCLE_COUNT_EN.
module clocks_6502
    import clocks_6502_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEFAULT,
    parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
    input  logic eclk,
    input  logic ereset,
    output logic _reset,
    output logic clk
);

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(RESET_CYCLES - 1);

    logic            rise;
    logic            fall;
    logic [FC_W-1:0] fc;

    clk_divider #(
        .DIV(CLK_DIV)
    ) u_div (
        .eclk  (eclk),
        .ereset(ereset),
        .clk   (clk),
        .rise  (rise),
        .fall  (fall)
    );

    // Releasing on a falling edge gives the CPU a full low phase of stable
    // _reset before it samples on the next rising edge.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            fc     <= '0;
            _reset <= 1'b0;
        end else if (fall && !_reset) begin
            fc <= fc + 1'b1;
            if (fc == FC_LAST) begin
                _reset <= 1'b1;
            end
        end
    end

`ifdef CLOCKS_6502_CYCLE_COUNT_EN
    logic [CYCLE_COUNT_W-1:0] cycle_count;

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            cycle_count <= '0;
        end else if (rise && _reset) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`endif

    strobes_exclusive: assert property (@(posedge eclk) disable iff (ereset) !(rise && fall));

endmodule

// File: tb/tb_clocks_6502.sv
// Self-checking bench for clocks_6502: a default instance plus one instance per
// CLK_DIV in 1..16 (RESET_CYCLES=1), checked against an edge-indexed model.
module tb_clocks_6502;

    logic        eclk;
    logic        ereset;
    logic        a_clk;
    logic        a_reset;
    logic [16:1] div_clk;
    logic [16:1] div_reset;

    int checks;
    int errors;
    int edge_n;

    logic [3:0] exp_q[$];
`ifdef CLOCKS_6502_CYCLE_COUNT_EN
    logic [31:0] cc_q[$];
`endif

    // ---------------- clock / reset block ----------------
    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    clocks_6502 u_a (
        .eclk  (eclk),
        .ereset(ereset),
        ._reset(a_reset),
        .clk   (a_clk)
    );

    for (genvar k = 1; k <= 16; k++) begin : g_div
        clocks_6502 #(
            .CLK_DIV     (k),
            .RESET_CYCLES(1)
        ) u_dut (
            .eclk  (eclk),
            .ereset(ereset),
            ._reset(div_reset[k]),
            .clk   (div_clk[k])
        );
    end

    // ---------------- reference model ----------------
    // e = index of eclk rising edges since ereset release (0 while in reset).
    function automatic logic model_clk(int e, int div);
        return (e > 0) && (((e / div) % 2) == 1);
    endfunction

    function automatic logic model_reset(int e, int div, int rc);
        return e >= 2 * div * rc;
    endfunction

    function automatic logic [31:0] model_cc(int e);
        return (e < 68) ? 32'd0 : 32'((e - 68) / 8 + 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(int n);
        int e_next;
        for (int i = 0; i < n; i++) begin
            e_next = ereset ? 0 : edge_n + 1;
            exp_q.push_back({model_clk(e_next, 4), model_reset(e_next, 4, 8),
                             model_clk(e_next, 1), model_reset(e_next, 1, 1)});
`ifdef CLOCKS_6502_CYCLE_COUNT_EN
            cc_q.push_back(model_cc(e_next));
`endif
            @(posedge eclk);
            #1;
            edge_n = e_next;
        end
        @(negedge eclk);
        #1;
    endtask

    task automatic pulse_reset(int hold);
        #1 ereset = 1'b1;
        step(hold);
        #1 ereset = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_reset_rise(output int e);
        e = -1;
        for (int i = 0; i < 200 && e < 0; i++) begin
            step(1);
            if (a_reset === 1'b1) e = edge_n;
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge eclk) begin
        logic [3:0] exp_v;
        logic [3:0] got_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {a_clk, a_reset, div_clk[1], div_reset[1]};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL waveform edge=%0d got={clk,_reset,clk1,_reset1}=%b expected=%b",
                         edge_n, got_v, exp_v);
            end
        end
`ifdef CLOCKS_6502_CYCLE_COUNT_EN
        if (cc_q.size() > 0) begin
            logic [31:0] exp_cc;
            exp_cc = cc_q.pop_front();
            checks++;
            if (u_a.cycle_count !== exp_cc) begin
                errors++;
                $display("FAIL cycle_count edge=%0d got=%0d expected=%0d",
                         edge_n, u_a.cycle_count, exp_cc);
            end
        end
`endif
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        step(100);
        checks++;
        if ({a_clk, a_reset} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold got={clk,_reset}=%b expected=00", {a_clk, a_reset});
        end
        checks++;
        if ({div_clk, div_reset} !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold_div got=%h expected=0", {div_clk, div_reset});
        end
    endtask

    task automatic test_release();
        int rise_e;
        int rst_e;
        #1 ereset = 1'b0;
        edge_n = 0;
        rise_e = -1;
        for (int i = 0; i < 20 && rise_e < 0; i++) begin
            step(1);
            if (a_clk === 1'b1) rise_e = edge_n;
        end
        checks++;
        if (rise_e != 4) begin
            errors++;
            $display("FAIL first_rise got=%0d expected=4", rise_e);
        end
        wait_reset_rise(rst_e);
        checks++;
        if (rst_e != 64) begin
            errors++;
            $display("FAIL reset_release got=%0d expected=64", rst_e);
        end
        checks++;
        if (a_clk !== 1'b0) begin
            errors++;
            $display("FAIL release_on_fall got clk=%b expected=0", a_clk);
        end
        step(90);
    endtask

    task automatic test_midreset_clk_high();
        int rst_e;
        pulse_reset(3);
        step(30);
        #1 ereset = 1'b1;
        #1;
        checks++;
        if ({a_clk, a_reset} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_clk_high got={clk,_reset}=%b expected=00", {a_clk, a_reset});
        end
        step(5);
        #1 ereset = 1'b0;
        edge_n = 0;
        wait_reset_rise(rst_e);
        checks++;
        if (rst_e != 64) begin
            errors++;
            $display("FAIL rerelease_after_clk_high got=%0d expected=64", rst_e);
        end
    endtask

    task automatic test_midreset_released();
        int rst_e;
        pulse_reset(2);
        step(200);
        checks++;
        if (a_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_sticky got=%b expected=1", a_reset);
        end
        #1 ereset = 1'b1;
        #1;
        checks++;
        if ({a_clk, a_reset} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_released got={clk,_reset}=%b expected=00", {a_clk, a_reset});
        end
        step(3);
        #1 ereset = 1'b0;
        edge_n = 0;
        wait_reset_rise(rst_e);
        checks++;
        if (rst_e != 64) begin
            errors++;
            $display("FAIL rerelease_after_run got=%0d expected=64", rst_e);
        end
    endtask

    task automatic test_random_div();
        int   d;
        int   prev_edge;
        int   phases;
        int   first_rise;
        int   rst_e;
        logic prev_clk;
        for (int t = 0; t < 5; t++) begin
            d = (t == 0) ? 16 : $urandom_range(1, 16);
            pulse_reset($urandom_range(1, 4));
            prev_clk   = 1'b0;
            prev_edge  = 0;
            phases     = 0;
            first_rise = -1;
            rst_e      = -1;
            for (int i = 0; i < 400 && phases < 6; i++) begin
                step(1);
                if (div_reset[d] === 1'b1 && rst_e < 0) rst_e = edge_n;
                if (div_clk[d] !== prev_clk) begin
                    if (first_rise < 0) begin
                        first_rise = edge_n;
                        checks++;
                        if (first_rise != d) begin
                            errors++;
                            $display("FAIL div%0d_first_rise got=%0d expected=%0d", d, first_rise, d);
                        end
                    end else begin
                        phases++;
                        checks++;
                        if (edge_n - prev_edge != d) begin
                            errors++;
                            $display("FAIL div%0d_phase got=%0d expected=%0d", d, edge_n - prev_edge, d);
                        end
                    end
                    prev_edge = edge_n;
                    prev_clk  = div_clk[d];
                end
            end
            checks++;
            if (phases != 6) begin
                errors++;
                $display("FAIL div%0d_timeout got phases=%0d expected=6", d, phases);
            end
            checks++;
            if (rst_e != 2 * d) begin
                errors++;
                $display("FAIL div%0d_reset_release got=%0d expected=%0d", d, rst_e, 2 * d);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        ereset = 1'b1;
        test_reset();
        test_release();
        test_midreset_clk_high();
        test_midreset_released();
        test_random_div();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
